// File: rtl/vga_sprite_renderer.sv
// VGA timing generator with a fixed-priority multi-sprite compositor.
// Sprite state is double-buffered at frame boundaries; pins lag the scan counters by two clocks.
module vga_sprite_renderer #(
   parameter int NUM_SPRITES    = 4,
   parameter int TILE_SIZE      = 32,
   parameter int COLOR_BITS     = 3,
   parameter int H_VISIBLE_AREA = 640,
   parameter int V_VISIBLE_AREA = 480,
   parameter int H_TOTAL        = 800,
   parameter int V_TOTAL        = 525,
   parameter int H_FRONT_PORCH  = 16,
   parameter int H_SYNC_PULSE   = 96,
   parameter int V_FRONT_PORCH  = 10,
   parameter int V_SYNC_PULSE   = 2
) (
   input  logic                                i_Clk,
   input  logic                                i_Rst_L,
   input  logic [10*NUM_SPRITES-1:0]           i_Sprite_X,
   input  logic [10*NUM_SPRITES-1:0]           i_Sprite_Y,
   input  logic [3*COLOR_BITS*NUM_SPRITES-1:0] i_Sprite_Color,
   input  logic [NUM_SPRITES-1:0]              i_Sprite_Enable,
   input  logic [3*COLOR_BITS-1:0]             i_Bg_Color,
   output logic                                o_VGA_HSync,
   output logic                                o_VGA_VSync,
   output logic [COLOR_BITS-1:0]               o_VGA_Red,
   output logic [COLOR_BITS-1:0]               o_VGA_Grn,
   output logic [COLOR_BITS-1:0]               o_VGA_Blu,
   output logic                                o_Frame_Start,
   output logic [NUM_SPRITES-1:0]              o_Collision
);

   localparam int PW = 3*COLOR_BITS;
   localparam int HW = $clog2(H_TOTAL);
   localparam int VW = $clog2(V_TOTAL);
   localparam int CW = 12;
   localparam logic [NUM_SPRITES-1:0] COLL_MASK = ~NUM_SPRITES'(1);

   logic [HW-1:0]               h_cnt;
   logic [VW-1:0]               v_cnt;
   logic                        h_last, v_last, frame_edge;
   logic [NUM_SPRITES-1:0]      en_sh;
   logic [10*NUM_SPRITES-1:0]   x_sh, y_sh;
   logic [PW*NUM_SPRITES-1:0]   col_sh;
   logic [NUM_SPRITES-1:0]      coll_acc;
   logic [CW-1:0]               h_ext, v_ext;
   logic [NUM_SPRITES-1:0]      hit;
   logic                        in_vis, hs_raw, vs_raw;
   logic [NUM_SPRITES-1:0]      hit_p1;
   logic                        vld_p1, hs_p1, vs_p1;
   logic [PW-1:0]               pix_p1;

   // Positions are widened before adding the tile so 10-bit inputs near 1023 cannot wrap.
   function automatic logic [CW-1:0] clamp_pos(input logic [9:0] pos, input logic [CW-1:0] limit);
      logic [CW-1:0] p;
      p = {{(CW-10){1'b0}}, pos};
      if (p + CW'(TILE_SIZE) > limit)
         return limit - CW'(TILE_SIZE);
      return p;
   endfunction

   assign h_last     = (h_cnt == HW'(H_TOTAL-1));
   assign v_last     = (v_cnt == VW'(V_TOTAL-1));
   assign frame_edge = h_last && v_last;

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         h_cnt         <= '0;
         v_cnt         <= '0;
         o_Frame_Start <= 1'b0;
         en_sh         <= '0;
         x_sh          <= '0;
         y_sh          <= '0;
         col_sh        <= '0;
         o_Collision   <= '0;
         coll_acc      <= '0;
      end else begin
         o_Frame_Start <= frame_edge;
         if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + 1'b1;
         end else begin
            h_cnt <= h_cnt + 1'b1;
         end
         if (frame_edge) begin
            en_sh       <= i_Sprite_Enable;
            x_sh        <= i_Sprite_X;
            y_sh        <= i_Sprite_Y;
            col_sh      <= i_Sprite_Color;
            o_Collision <= coll_acc;
            coll_acc    <= '0;
         end else if (hit_p1[0]) begin
            coll_acc <= coll_acc | (hit_p1 & COLL_MASK);
         end
      end
   end

   // Stage 0: hit test of the current scan position against the shadowed sprites
   assign h_ext  = CW'(h_cnt);
   assign v_ext  = CW'(v_cnt);
   assign in_vis = (h_ext < CW'(H_VISIBLE_AREA)) && (v_ext < CW'(V_VISIBLE_AREA));
   assign hs_raw = !((h_ext >= CW'(H_VISIBLE_AREA+H_FRONT_PORCH)) &&
                     (h_ext <  CW'(H_VISIBLE_AREA+H_FRONT_PORCH+H_SYNC_PULSE)));
   assign vs_raw = !((v_ext >= CW'(V_VISIBLE_AREA+V_FRONT_PORCH)) &&
                     (v_ext <  CW'(V_VISIBLE_AREA+V_FRONT_PORCH+V_SYNC_PULSE)));

   always_comb begin
      logic [CW-1:0] xk, yk;
      hit = '0;
      xk  = '0;
      yk  = '0;
      for (int k = 0; k < NUM_SPRITES; k++) begin
         xk = clamp_pos(x_sh[10*k +: 10], CW'(H_VISIBLE_AREA));
         yk = clamp_pos(y_sh[10*k +: 10], CW'(V_VISIBLE_AREA));
         hit[k] = en_sh[k] && in_vis &&
                  (h_ext >= xk) && (h_ext < xk + CW'(TILE_SIZE)) &&
                  (v_ext >= yk) && (v_ext < yk + CW'(TILE_SIZE));
      end
   end

   // Stage 1: register hit vector, visibility and raw syncs
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         hit_p1 <= '0;
         vld_p1 <= 1'b0;
         hs_p1  <= 1'b1;
         vs_p1  <= 1'b1;
      end else begin
         hit_p1 <= hit;
         vld_p1 <= in_vis;
         hs_p1  <= hs_raw;
         vs_p1  <= vs_raw;
      end
   end

   always_comb begin
      pix_p1 = i_Bg_Color;
      for (int k = NUM_SPRITES-1; k >= 0; k--)
         if (hit_p1[k]) pix_p1 = col_sh[PW*k +: PW];
      if (!vld_p1) pix_p1 = '0;
   end

   // Stage 2: colour and syncs to the pins
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         o_VGA_Red   <= '0;
         o_VGA_Grn   <= '0;
         o_VGA_Blu   <= '0;
         o_VGA_HSync <= 1'b1;
         o_VGA_VSync <= 1'b1;
      end else begin
         {o_VGA_Red, o_VGA_Grn, o_VGA_Blu} <= pix_p1;
         o_VGA_HSync <= hs_p1;
         o_VGA_VSync <= vs_p1;
      end
   end

endmodule

// File: doc/vga_sprite_renderer.md
Name: vga_sprite_renderer

Overview:
Parametrised VGA timing generator and multi-sprite compositor. It scans a configurable frame and draws up to NUM_SPRITES solid rectangular sprites in fixed priority over a background colour. Sprite inputs are double-buffered at frame boundaries, the output path is pipelined, and per-frame sprite-0 collision flags are reported. It sits between game logic (player/vehicle position registers) and the VGA pins.

Parameters:
NUM_SPRITES, 4, number of sprite channels (1..8); index 0 is highest priority.
TILE_SIZE, 32, sprite width and height in pixels.
COLOR_BITS, 3, bits per colour channel.
H_VISIBLE_AREA, 640, visible pixels per line.
V_VISIBLE_AREA, 480, visible lines per frame.
H_TOTAL, 800, clocks per line.
V_TOTAL, 525, lines per frame.
H_FRONT_PORCH, 16, horizontal front porch in clocks.
H_SYNC_PULSE, 96, HSync low width in clocks.
V_FRONT_PORCH, 10, vertical front porch in lines.
V_SYNC_PULSE, 2, VSync low width in lines.

Ports:
i_Clk  in  1  pixel clock.
i_Rst_L  in  1  asynchronous active-low reset.
i_Sprite_X  in  10*NUM_SPRITES  top-left X per sprite; sprite k uses bits [10k+9:10k].
i_Sprite_Y  in  10*NUM_SPRITES  top-left Y per sprite, packed the same way.
i_Sprite_Color  in  3*COLOR_BITS*NUM_SPRITES  {R,G,B} per sprite, packed the same way.
i_Sprite_Enable  in  NUM_SPRITES  sprite k is drawn when bit k is 1.
i_Bg_Color  in  3*COLOR_BITS  {R,G,B} background for the visible area.
o_VGA_HSync  out  1  horizontal sync, active low.
o_VGA_VSync  out  1  vertical sync, active low.
o_VGA_Red  out  COLOR_BITS  red.
o_VGA_Grn  out  COLOR_BITS  green.
o_VGA_Blu  out  COLOR_BITS  blue.
o_Frame_Start  out  1  one-cycle pulse at frame boundary.
o_Collision  out  NUM_SPRITES  bit k=1 if sprite k overlapped sprite 0 in the previous frame; bit 0 is always 0.

Behaviour:
- Reset (async, while i_Rst_L=0): h/v counters 0; HSync/VSync 1; colours 0; o_Frame_Start 0; o_Collision 0; shadow enables 0; shadow X/Y/colour 0; collision accumulator 0.
- Counters: h increments 0..H_TOTAL-1 and wraps; v increments when h wraps, 0..V_TOTAL-1, then wraps.
- Frame boundary: the edge where (h,v) goes (H_TOTAL-1,V_TOTAL-1) to (0,0). On this edge, shadow registers load all i_Sprite_* inputs, o_Collision loads the accumulator, and the accumulator clears. o_Frame_Start is 1 exactly while (h,v)=(0,0). i_Bg_Color is not shadowed.
- Input changes outside the boundary edge have no effect on the frame being drawn.
- Clamping is computed in 11 bits on shadow values: if X+TILE_SIZE > H_VISIBLE_AREA, X' = H_VISIBLE_AREA-TILE_SIZE. Y uses the same rule against V_VISIBLE_AREA. Values up to 1023 must not wrap.
- Hit: hit[k] = enable[k] && X'k <= h < X'k+TILE_SIZE && Y'k <= v < Y'k+TILE_SIZE && h < H_VISIBLE_AREA && v < V_VISIBLE_AREA.
- Pipeline stage 1 registers the hit vector, a visible flag, and raw HSync/VSync. Raw sync is low for H_VISIBLE_AREA+H_FRONT_PORCH <= h < H_VISIBLE_AREA+H_FRONT_PORCH+H_SYNC_PULSE; VSync uses the same rule with v.
- Pipeline stage 2: colour is the lowest-index hit sprite's colour; if no sprite hits, i_Bg_Color; outside the visible area, 0. Syncs are delayed one more cycle.
- Latency: pins reflect counter value (h,v) exactly 2 cycles later. Sync and colour stay mutually aligned.
- Collision: on each stage-1 cycle with hit[0]=1, set acc[k] for every k>=1 with hit[k]=1. A hit on the last visible pixel is included before the boundary.
- Reset mid-frame restarts at (0,0) with shadow enables 0, so only the background is drawn until the next boundary.

Test Plan:
- Reset held, then released at cycle 0 -> HSync/VSync=1 and colours=0 during reset. First HSync falls at cycle 658 and stays low 96 cycles. VSync goes low on line 490 for 2 lines.
- Sprite 0 enabled at X=100, Y=50, colour all 1s, bg=0, inputs set before the boundary -> next frame pixels (100..131, 50..81) are 3'b111 on all channels; pixels (99,50), (132,50) and (100,82) are 0.
- Sprite 0 red at (200,200) and sprite 1 blue at (210,210) -> pixel (215,215) is red, (235,235) is blue, (205,205) is red.
- Sprite 2 at X=630, Y=470 -> drawn at 608..639 x 448..479. X=1020 also clamps to 608 with no wrap.
- Sprite 0 X changed from 100 to 300 during line 100 -> the rest of that frame is drawn at 100. o_Frame_Start pulses and the next frame is drawn at 300.
- Sprites 0 and 1 overlapping in frame N -> o_Collision=4'b0010 during frame N+1. Sprites separated in frame N+1 -> o_Collision=0 during frame N+2. Overlap with sprite 1 disabled -> 0.
